// File: rtl/router_pkg.sv
// Shared router definitions: flit field layout, flit type and allocator state encodings.
// Latency: none (definitions only).
// Backpressure: not applicable.
package router_pkg;

  localparam int FLIT_WIDTH       = 64;
  localparam int MESH_SIZE_X      = 4;
  localparam int MESH_SIZE_Y      = 4;
  localparam int DEST_ADDR_SIZE_X = $clog2(MESH_SIZE_X);
  localparam int DEST_ADDR_SIZE_Y = $clog2(MESH_SIZE_Y);

  // Flit field bit positions, counted from the MSB of a FLIT_WIDTH flit.
  localparam int DEST_X_MSB  = 63;
  localparam int DEST_X_LSB  = 62;
  localparam int DEST_Y_MSB  = 61;
  localparam int DEST_Y_LSB  = 60;
  localparam int TYPE_MSB    = 59;
  localparam int TYPE_LSB    = 58;
  localparam int PAYLOAD_MSB = 57;

  typedef enum logic [1:0] {
    BODY      = 2'b00,
    TAIL      = 2'b01,
    HEAD      = 2'b10,
    HEAD_TAIL = 2'b11
  } flit_type_e;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } alloc_state_e;

  function automatic flit_type_e get_flit_type(input logic [FLIT_WIDTH-1:0] flit);
    return flit_type_e'(flit[TYPE_MSB:TYPE_LSB]);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first set bit of req scanning upward from ptr with wrap-around.
// Latency: purely combinational, zero cycles; holds no state.
// Backpressure: none; the caller decides whether the pick is consumed.
module rr_arbiter #(
  parameter int NUM_INPUTS = 5,
  parameter int IDX_W      = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic [NUM_INPUTS-1:0] req,
  input  logic [IDX_W-1:0]      ptr,
  output logic [NUM_INPUTS-1:0] gnt,
  output logic [IDX_W-1:0]      idx,
  output logic                  any
);

  logic [IDX_W:0] pos;

  // Walk the ring starting at ptr; the first requester found wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      pos = {1'b0, ptr} + (IDX_W+1)'(i);
      if (pos >= (IDX_W+1)'(NUM_INPUTS)) begin
        pos = pos - (IDX_W+1)'(NUM_INPUTS);
      end
      if (!any && req[pos[IDX_W-1:0]]) begin
        any                  = 1'b1;
        gnt[pos[IDX_W-1:0]]  = 1'b1;
        idx                  = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/output_port_allocator.sv
// Wormhole output-port allocator: round-robin pick of an input buffer, locked from head to tail.
// Latency: pop/push/out_flit are combinational (same cycle); grant updates on the next clock.
// Backpressure: down_full or a missing locked request stalls with no strobes; optional
//   stall timeout under OUTPUT_PORT_ALLOCATOR_TIMEOUT_EN releases a stuck lock.
module output_port_allocator #(
  parameter int NUM_INPUTS     = 5,
  parameter int FLIT_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_INPUTS-1:0]            in_req,
  input  logic [NUM_INPUTS*FLIT_WIDTH-1:0] in_flit,
  input  logic                             down_full,
  output logic [NUM_INPUTS-1:0]            in_pop,
  output logic [FLIT_WIDTH-1:0]            out_flit,
  output logic                             out_push,
  output logic [NUM_INPUTS-1:0]            grant,
  output logic                             lock_timeout
);

  import router_pkg::*;

  localparam int IDX_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;

  alloc_state_e          state, state_nxt;
  logic [IDX_W-1:0]      rr_ptr, rr_ptr_nxt, lock_idx, lock_idx_nxt;
  logic [IDX_W-1:0]      arb_idx, sel, sel_inc;
  logic [NUM_INPUTS-1:0] arb_gnt, sel_onehot, grant_nxt;
  logic                  arb_any, sel_req, xfer, timeout_fire;
  logic [FLIT_WIDTH-1:0] flit_arr [NUM_INPUTS];
  logic [FLIT_WIDTH-1:0] sel_flit;
  flit_type_e            sel_type;

  for (genvar k = 0; k < NUM_INPUTS; k++) begin : g_unpack
    assign flit_arr[k] = in_flit[k*FLIT_WIDTH +: FLIT_WIDTH];
  end

  rr_arbiter #(
    .NUM_INPUTS (NUM_INPUTS),
    .IDX_W      (IDX_W)
  ) u_rr_arbiter (
    .req (in_req),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // Source select: arbiter winner when idle, the locked owner otherwise (others ignored).
  always_comb begin
    sel        = arb_idx;
    sel_onehot = arb_gnt;
    sel_req    = arb_any;
    if (state == LOCKED) begin
      sel        = lock_idx;
      sel_onehot = grant;
      sel_req    = in_req[lock_idx];
    end
  end

  assign sel_flit = flit_arr[sel];
  assign sel_type = flit_type_e'(sel_flit[TYPE_MSB:TYPE_LSB]);
  assign sel_inc  = (sel == IDX_W'(NUM_INPUTS-1)) ? '0 : sel + IDX_W'(1);
  // rst gates the strobes so a flit cannot be moved during reset.
  assign xfer     = sel_req && !down_full && !rst;
  assign in_pop   = xfer ? sel_onehot : '0;
  assign out_push = xfer;
  assign out_flit = xfer ? sel_flit : '0;

`ifdef OUTPUT_PORT_ALLOCATOR_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES+1);
  logic [STALL_W-1:0] stall_cnt;

  // Fires on the TIMEOUT_CYCLES-th consecutive locked stall cycle.
  assign timeout_fire = (state == LOCKED) && !xfer && !rst &&
                        (stall_cnt == STALL_W'(TIMEOUT_CYCLES-1));

  // Count consecutive locked stall cycles; any transfer, idle or release restarts it.
  always_ff @(posedge clk) begin
    if (rst || state != LOCKED || xfer || timeout_fire) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + STALL_W'(1);
    end
  end
`else
  // Without the timeout a lock is held until its tail transfers.
  assign timeout_fire = 1'b0;
`endif

  assign lock_timeout = timeout_fire;

  // Next-state: lock on HEAD, release on TAIL/HEAD_TAIL or timeout, advance rr past the owner.
  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    lock_idx_nxt = lock_idx;
    rr_ptr_nxt   = rr_ptr;
    case (state)
      IDLE: begin
        if (xfer) begin
          if (sel_type == HEAD) begin
            state_nxt    = LOCKED;
            grant_nxt    = sel_onehot;
            lock_idx_nxt = sel;
          end else begin
            // HEAD_TAIL, or a stray BODY/TAIL: single-flit packet, move on.
            rr_ptr_nxt = sel_inc;
          end
        end
      end
      LOCKED: begin
        if ((xfer && (sel_type == TAIL || sel_type == HEAD_TAIL)) || timeout_fire) begin
          state_nxt  = IDLE;
          grant_nxt  = '0;
          rr_ptr_nxt = sel_inc;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  // State register with synchronous reset; reset drops any lock.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      lock_idx <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      rr_ptr   <= rr_ptr_nxt;
      lock_idx <= lock_idx_nxt;
    end
  end

  a_idle_no_body: assert property (@(posedge clk) disable iff (rst)
    (state == IDLE && xfer) |-> !(sel_type inside {BODY, TAIL}));

  a_locked_no_head: assert property (@(posedge clk) disable iff (rst)
    (state == LOCKED && xfer) |-> (sel_type != HEAD));

  a_params: assert property (@(posedge clk) (NUM_INPUTS >= 2) && (TIMEOUT_CYCLES >= 1));

endmodule

// File: doc/output_port_allocator.md
Name: output_port_allocator

Overview:
- Per-output-port allocator for the wormhole router. Shares one output link between NUM_INPUTS input circular buffers.
- Picks one requesting input buffer by round-robin and locks the output to it from head flit to tail flit (wormhole).
- While locked, generates that buffer's pop and the downstream buffer's push; forwards the flit combinationally.
- One instance per router output port (N/S/E/W/local).

Parameters:
- NUM_INPUTS, 5, number of input buffers competing for this output.
- FLIT_WIDTH, 64, flit width in bits.
- TIMEOUT_CYCLES, 64, stall limit while locked; used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- in_req  in  NUM_INPUTS  per input: a flit is available at that buffer's head and is routed to this port (buffer not empty and route matches).
- in_flit  in  NUM_INPUTS*FLIT_WIDTH  head flits of all buffers; input k occupies bits [k*FLIT_WIDTH +: FLIT_WIDTH].
- down_full  in  1  downstream buffer full.
- in_pop  out  NUM_INPUTS  one-hot pop strobe to the winning input buffer.
- out_flit  out  FLIT_WIDTH  flit forwarded to the downstream buffer.
- out_push  out  1  push strobe to the downstream buffer.
- grant  out  NUM_INPUTS  one-hot current owner while locked; 0 when idle.
- lock_timeout  out  1  one-cycle stall-timeout pulse; tied 0 without the feature.

Behaviour:
- Flit format:
  - [63:62] dest X.
  - [61:60] dest Y.
  - [59:58] type: HEAD=2'b10, BODY=2'b00, TAIL=2'b01, HEAD_TAIL=2'b11.
  - [57:0] payload.
- Reset (rst=1 at posedge):
  - state=IDLE, grant=0, rr_ptr=0.
  - in_pop=0, out_push=0, lock_timeout=0, out_flit=0. out_push and in_pop are forced 0 combinationally while rst is high.
- Transfer condition: xfer = selected input's in_req AND ~down_full.
- On xfer (same cycle, combinational, zero latency):
  - in_pop[sel]=1, out_push=1, out_flit=in_flit[sel].
  - Otherwise out_flit=0 and no strobes.
- IDLE:
  - sel = first set bit of in_req, scanning from rr_ptr upward with wrap-around (rr_ptr has highest priority).
  - If no request, or down_full: no transfer, stay IDLE, rr_ptr unchanged.
  - On xfer of a HEAD: next state LOCKED, grant<=onehot(sel).
  - On xfer of a HEAD_TAIL: stay IDLE, rr_ptr<=(sel+1) mod NUM_INPUTS.
  - BODY or TAIL seen at an idle winner is a protocol error: the flit is still forwarded, state stays IDLE, rr_ptr advances. An assertion flags it in simulation.
- LOCKED:
  - sel = grant index. Other inputs are ignored regardless of in_req.
  - Stall (in_req[sel]=0 or down_full=1): hold grant, no strobes.
  - xfer of BODY: stay LOCKED.
  - xfer of TAIL (or HEAD_TAIL): next state IDLE, grant<=0, rr_ptr<=(sel+1) mod NUM_INPUTS.
  - A HEAD seen while locked is treated as BODY; an assertion fires.
- Back-to-back: the packet after a tail can be granted in the cycle immediately following the tail transfer.
- Fairness: a requester waits at most NUM_INPUTS-1 packets.
- down_full sampled high blocks every transfer that cycle; the buffer's full flag is combinationally current.
- rst asserted mid-packet: lock is dropped and grant cleared. Buffer flushing is the upstream owner's responsibility.

Optional Feature:
- Macro: OUTPUT_PORT_ALLOCATOR_TIMEOUT_EN.
- Defined:
  - Stall counter, width $clog2(TIMEOUT_CYCLES+1); resets to 0 and clears on every xfer or when IDLE.
  - Increments each LOCKED stall cycle.
  - On reaching TIMEOUT_CYCLES: lock_timeout=1 for one cycle, force IDLE, grant<=0, rr_ptr<=sel+1, counter<=0.
- Undefined: no counter; lock_timeout tied 0; a lock is held indefinitely.

Decomposition:
- Package router_pkg holds:
  - FLIT_WIDTH, MESH_SIZE_X, DEST_ADDR_SIZE_X/Y.
  - Field bit positions.
  - flit_type_e enum (HEAD, BODY, TAIL, HEAD_TAIL).
  - alloc_state_e enum (IDLE, LOCKED).
- Sub-module rr_arbiter: purely combinational. Takes req[NUM_INPUTS] and ptr, returns one-hot gnt and index. The allocator owns all state.

Test Plan:
- Single packet: in_req=5'b00100 with HEAD,BODY,BODY,TAIL and down_full=0 -> in_pop[2]=1 and out_push=1 on 4 consecutive cycles; grant=5'b00100 through the tail; rr_ptr=3 after.
- Contention: inputs 0 and 3 each send a 3-flit packet, rr_ptr=0 -> input 0's packet completes uninterrupted, then input 3 is granted the next cycle; no interleaving on out_flit.
- Backpressure: down_full=1 for 3 cycles mid-packet -> no in_pop/out_push during those cycles, grant held; transfer resumes the cycle down_full drops.
- Bubble: locked input deasserts in_req for 2 cycles while input 1 requests -> input 1 is not granted until the locked packet's TAIL transfers.
- HEAD_TAIL packets from inputs 0,1,2 requesting simultaneously -> granted in order 0,1,2 on consecutive cycles; state stays IDLE.
- Reset mid-packet after the HEAD -> next cycle grant=0, state IDLE, no strobes. With OUTPUT_PORT_ALLOCATOR_TIMEOUT_EN and TIMEOUT_CYCLES=8: a 8-cycle stall -> lock_timeout pulses once and grant=0.
